// File: rtl/key_event_decoder.sv
// Debounced key level to one-cycle press/release/short/double/long/repeat pulses.
// Latency: one cycle from key_in to key_level/press/release; no backpressure, pulses are fire-and-forget.
module key_event_decoder #(
  parameter int ACTIVE_LOW        = 1,
  parameter int LONG_CYCLES       = 16,
  parameter int DCLICK_GAP_CYCLES = 8,
  parameter int REPEAT_CYCLES     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  input  logic enable,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int MAX_A  = (LONG_CYCLES > DCLICK_GAP_CYCLES) ? LONG_CYCLES : DCLICK_GAP_CYCLES;
  localparam int MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((DCLICK_GAP_CYCLES > 0) ? DCLICK_GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          act;
  logic          rise;
  logic          fall;

  // armed stays low for the first cycle after reset so a key held through
  // reset release only loads key_level and never looks like a fresh press.
  assign act  = key_in ^ (ACTIVE_LOW != 0);
  assign rise = armed & act & ~key_level;
  assign fall = armed & ~act & key_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      armed         <= 1'b0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      double_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      key_level     <= act;
      armed         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      double_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              press_pulse <= 1'b1;
              state       <= PRESS1;
              busy        <= 1'b1;
            end
          end

          // Release is tested before the threshold so it wins on the same edge.
          PRESS1: begin
            if (fall) begin
              release_pulse <= 1'b1;
              cnt           <= '0;
              if (DCLICK_GAP_CYCLES == 0) begin
                short_pulse <= 1'b1;
                state       <= IDLE;
                busy        <= 1'b0;
              end else begin
                state <= WAIT_GAP;
              end
            end else if (cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              state      <= LONG_HOLD;
              cnt        <= '0;
            end
          end

          WAIT_GAP: begin
            if (rise) begin
              press_pulse <= 1'b1;
              state       <= PRESS2;
              cnt         <= '0;
            end else if (cnt == GAP_LAST) begin
              short_pulse <= 1'b1;
              state       <= IDLE;
              cnt         <= '0;
              busy        <= 1'b0;
            end
          end

          PRESS2: begin
            if (fall) begin
              release_pulse <= 1'b1;
              double_pulse  <= 1'b1;
              state         <= IDLE;
              cnt           <= '0;
              busy          <= 1'b0;
            end else if (cnt == LONG_LAST) begin
              short_pulse <= 1'b1;
              long_pulse  <= 1'b1;
              state       <= LONG_HOLD;
              cnt         <= '0;
            end
          end

          LONG_HOLD: begin
            if (fall) begin
              release_pulse <= 1'b1;
              state         <= IDLE;
              cnt           <= '0;
              busy          <= 1'b0;
            end else if (cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              cnt          <= '0;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: timestamp-based reference model, scenario table, directed corners, random run.
module tb_key_event_decoder;

  localparam int L = 16;
  localparam int G = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n, key_in, enable;
  logic key_level, press_pulse, release_pulse, short_pulse;
  logic double_pulse, long_pulse, repeat_pulse, busy;

  always #5 clk = ~clk;

  key_event_decoder #(
    .ACTIVE_LOW(1), .LONG_CYCLES(L), .DCLICK_GAP_CYCLES(G), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .enable(enable),
    .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .short_pulse(short_pulse), .double_pulse(double_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int now    = 0;

  // Reference model: gesture described by press count, hold flag and event timestamps.
  bit m_armed, m_lvl, m_down, m_long;
  int m_clicks, m_tp, m_tr, m_tl;
  logic [7:0] exp_v;

  // Observed pulse statistics
  int n_press, n_rel, n_short, n_dbl, n_long, n_rep, n_pair, n_any;
  int t_press, t_rel, t_short, t_long, t_rep1;

  task automatic model_step();
    bit act, rise, fall;
    bit e_p, e_r, e_s, e_d, e_l, e_rp;
    e_p = 0; e_r = 0; e_s = 0; e_d = 0; e_l = 0; e_rp = 0;
    if (!rst_n) begin
      m_armed = 0; m_lvl = 0; m_down = 0; m_long = 0; m_clicks = 0;
      exp_v = '0;
      return;
    end
    act  = ~key_in;
    rise = m_armed && act && !m_lvl;
    fall = m_armed && !act && m_lvl;
    if (!enable) begin
      m_clicks = 0; m_down = 0; m_long = 0;
    end else if (m_clicks == 0) begin
      if (rise) begin
        e_p = 1; m_clicks = 1; m_down = 1; m_tp = now;
      end
    end else if (m_long) begin
      if (fall) begin
        e_r = 1; m_clicks = 0; m_down = 0; m_long = 0;
      end else if ((now - m_tl) % R == 0) begin
        e_rp = 1;
      end
    end else if (m_down) begin
      if (fall) begin
        e_r = 1;
        if (m_clicks == 2) begin
          e_d = 1; m_clicks = 0; m_down = 0;
        end else if (G == 0) begin
          e_s = 1; m_clicks = 0; m_down = 0;
        end else begin
          m_down = 0; m_tr = now;
        end
      end else if (now - m_tp == L) begin
        e_l = 1; e_s = (m_clicks == 2); m_long = 1; m_tl = now;
      end
    end else begin
      if (rise) begin
        e_p = 1; m_clicks = 2; m_down = 1; m_tp = now;
      end else if (now - m_tr == G) begin
        e_s = 1; m_clicks = 0;
      end
    end
    m_lvl   = act;
    m_armed = 1;
    exp_v   = {act, e_p, e_r, e_s, e_d, e_l, e_rp, (m_clicks != 0)};
  endtask

  task automatic chk(input string name, input int act_v, input int exp_val);
    checks++;
    if (act_v != exp_val) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act_v, exp_val, now);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_short = 0; n_dbl = 0; n_long = 0; n_rep = 0;
    n_pair = 0; n_any = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_long = -1; t_rep1 = -1;
  endtask

  task automatic tick();
    logic [7:0] got;
    @(posedge clk);
    now++;
    model_step();
    @(negedge clk);
    got = {key_level, press_pulse, release_pulse, short_pulse, double_pulse,
           long_pulse, repeat_pulse, busy};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL model cycle %0d: got %b expected %b (lvl,prs,rel,sht,dbl,lng,rep,busy)",
               now, got, exp_v);
    end
    if (press_pulse)   begin n_press++; t_press = now; end
    if (release_pulse) begin n_rel++;   t_rel   = now; end
    if (short_pulse)   begin n_short++; t_short = now; end
    if (double_pulse)  n_dbl++;
    if (long_pulse)    begin n_long++;  t_long  = now; end
    if (repeat_pulse)  begin if (n_rep == 0) t_rep1 = now; n_rep++; end
    if (short_pulse && long_pulse) n_pair++;
    if (press_pulse | release_pulse | short_pulse | double_pulse | long_pulse | repeat_pulse)
      n_any++;
  endtask

  task automatic hold(input bit pressed, input int n);
    key_in = ~pressed;
    repeat (n) tick();
  endtask

  typedef struct {
    int h1; int gap; int h2;
    int np; int nr; int ns; int nd; int nl; int nrep;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int c0, t_l;
    rst_n  = 1'b0;
    key_in = 1'b1;
    enable = 1'b1;
    clear_counts();

    vecs[0] = '{5,  0, 0,  1, 1, 1, 0, 0, 0};  // plain click
    vecs[1] = '{3,  4, 3,  2, 2, 0, 1, 0, 0};  // double click
    vecs[2] = '{30, 0, 0,  1, 1, 0, 0, 1, 3};  // long press with repeats
    vecs[3] = '{16, 0, 0,  1, 1, 1, 0, 0, 0};  // release on long threshold
    vecs[4] = '{15, 0, 0,  1, 1, 1, 0, 0, 0};
    vecs[5] = '{17, 0, 0,  1, 1, 0, 0, 1, 0};
    vecs[6] = '{3,  8, 3,  2, 2, 0, 1, 0, 0};  // second press at gap limit
    vecs[7] = '{3,  9, 3,  2, 2, 2, 0, 0, 0};  // one past gap limit
    vecs[8] = '{3,  4, 20, 2, 2, 1, 0, 1, 0};  // release on first repeat edge
    vecs[9] = '{3,  4, 24, 2, 2, 1, 0, 1, 1};

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", {key_level, press_pulse, release_pulse, short_pulse,
                          double_pulse, long_pulse, repeat_pulse, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 3);

    // Scenario table
    for (int i = 0; i < 10; i++) begin
      clear_counts();
      hold(1, vecs[i].h1);
      if (vecs[i].h2 > 0) begin
        hold(0, vecs[i].gap);
        hold(1, vecs[i].h2);
      end
      hold(0, 12);
      chk($sformatf("vec%0d_press", i),   n_press, vecs[i].np);
      chk($sformatf("vec%0d_release", i), n_rel,   vecs[i].nr);
      chk($sformatf("vec%0d_short", i),   n_short, vecs[i].ns);
      chk($sformatf("vec%0d_double", i),  n_dbl,   vecs[i].nd);
      chk($sformatf("vec%0d_long", i),    n_long,  vecs[i].nl);
      chk($sformatf("vec%0d_repeat", i),  n_rep,   vecs[i].nrep);
      chk($sformatf("vec%0d_busy", i),    busy,    0);
    end

    // Single click timing
    clear_counts();
    c0 = now;
    hold(1, 5);
    hold(0, 12);
    chk("click_press_latency", t_press - c0, 1);
    chk("click_release_delay", t_rel - t_press, 5);
    chk("click_short_delay", t_short - t_rel, 8);

    // Long press timing
    clear_counts();
    hold(1, 30);
    chk("long_delay", t_long - t_press, 16);
    chk("first_repeat_delay", t_rep1 - t_long, 4);
    chk("repeat_count", n_rep, 3);
    hold(0, 12);

    // Click then long: short and long together
    clear_counts();
    hold(1, 3);
    hold(0, 4);
    hold(1, 18);
    t_l = t_press;
    chk("click_long_pair", n_pair, 1);
    chk("click_long_delay", t_long - t_l, 16);
    hold(0, 12);

    // Disable mid-hold, re-enable while held
    clear_counts();
    hold(1, 10);
    clear_counts();
    enable = 1'b0;
    hold(1, 20);
    chk("disable_pulses", n_any, 0);
    chk("disable_busy", busy, 0);
    chk("disable_level", key_level, 1);
    enable = 1'b1;
    hold(1, 20);
    chk("reenable_no_press", n_press, 0);
    chk("reenable_no_events", n_any, 0);
    hold(0, 12);

    // Reset during WAIT_GAP
    clear_counts();
    hold(1, 3);
    hold(0, 3);
    chk("wait_gap_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy, 0);
    hold(0, 2);
    chk("reset_gap_outputs", {key_level, press_pulse, release_pulse, short_pulse,
                              double_pulse, long_pulse, repeat_pulse, busy}, 0);
    rst_n = 1'b1;
    clear_counts();
    hold(0, 12);
    chk("reset_gap_no_short", n_short, 0);

    // Key held through reset release
    rst_n = 1'b0;
    hold(1, 2);
    rst_n = 1'b1;
    clear_counts();
    hold(1, 3);
    chk("held_reset_no_press", n_press, 0);
    chk("held_reset_level", key_level, 1);
    hold(0, 12);

    // Random stimulus against the model
    for (int k = 0; k < 250; k++) begin
      bit p;
      p = ($urandom_range(0, 1) == 1);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        hold(p, 1);
        rst_n = 1'b1;
      end
      hold(p, $urandom_range(1, 24));
    end
    enable = 1'b1;
    hold(0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
